// File: rtl/regfile_commit_ctrl_pkg.sv
// Shared CPU defines for the regfile commit path:
// ROB/register/data widths and the commit FSM encoding.
package regfile_commit_ctrl_pkg;

    localparam int ROB_WIDTH    = 4;
    localparam int REG_ID_WIDTH = 5;
    localparam int XLEN         = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } cq_state_e;

    typedef struct packed {
        logic [REG_ID_WIDTH-1:0] reg_id;
        logic [XLEN-1:0]         val;
        logic [ROB_WIDTH-1:0]    rob_id;
    } cq_entry_t;

endpackage

// File: rtl/regfile_commit_fifo.sv
// commit_fifo: in-order circular commit queue with
// wrapping head/tail pointers, occupancy and per-entry valid bits.
module commit_fifo
    import regfile_commit_ctrl_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic                          push_en,
    input  logic [REG_ID_WIDTH-1:0]       push_reg_id,
    input  logic [XLEN-1:0]               push_val,
    input  logic [ROB_WIDTH-1:0]          push_rob_id,
    input  logic                          pop_en,
    output logic [REG_ID_WIDTH-1:0]       head_reg_id,
    output logic [XLEN-1:0]               head_val,
    output logic [ROB_WIDTH-1:0]          head_rob_id,
    output logic [CW-1:0]                 count,
    output logic [PW-1:0]                 head_ptr,
    output logic [DEPTH-1:0]              ent_vld,
    output logic [DEPTH*REG_ID_WIDTH-1:0] ent_reg_id,
    output logic [DEPTH*XLEN-1:0]         ent_val
);

    cq_entry_t        mem_q [DEPTH];
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [CW-1:0]    count_q;
    logic [DEPTH-1:0] vld_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
        end else begin
            if (pop_en) begin
                head_q        <= head_q + 1'b1;
                vld_q[head_q] <= 1'b0;
            end
            if (push_en) begin
                tail_q        <= tail_q + 1'b1;
                vld_q[tail_q] <= 1'b1;
            end
            unique case ({push_en, pop_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload needs no reset: valid bits gate every use.
    always_ff @(posedge clk_in) begin
        if (push_en) begin
            mem_q[tail_q] <= '{push_reg_id, push_val, push_rob_id};
        end
    end

    always_comb begin
        ent_reg_id = '0;
        ent_val    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_reg_id[i*REG_ID_WIDTH +: REG_ID_WIDTH] = mem_q[i].reg_id;
            ent_val[i*XLEN +: XLEN]                    = mem_q[i].val;
        end
    end

    assign head_reg_id = mem_q[head_q].reg_id;
    assign head_val    = mem_q[head_q].val;
    assign head_rob_id = mem_q[head_q].rob_id;
    assign count       = count_q;
    assign head_ptr    = head_q;
    assign ent_vld     = vld_q;

endmodule

// File: rtl/regfile_commit_ctrl.sv
// Regfile commit controller: queues ROB results, drains one per cycle.
// Define COMMIT_BYPASS_EN for a 0-cycle path when the queue is empty.
module regfile_commit_ctrl
    import regfile_commit_ctrl_pkg::*;
#(
    parameter  int CQ_DEPTH = 4,
    localparam int PW       = $clog2(CQ_DEPTH),
    localparam int CW       = PW + 1
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    rdy_in,
    input  logic                    clear,
    input  logic                    cq_valid,
    output logic                    cq_ready,
    input  logic [REG_ID_WIDTH-1:0] cq_reg_id,
    input  logic [XLEN-1:0]         cq_val,
    input  logic [ROB_WIDTH-1:0]    cq_rob_id,
    output logic                    commit_ready,
    output logic [REG_ID_WIDTH-1:0] commit_reg_id,
    output logic [XLEN-1:0]         commit_val,
    output logic [ROB_WIDTH-1:0]    commit_rob_id,
    input  logic [REG_ID_WIDTH-1:0] fwd_reg_1,
    output logic                    fwd_hit_1,
    output logic [XLEN-1:0]         fwd_val_1,
    input  logic [REG_ID_WIDTH-1:0] fwd_reg_2,
    output logic                    fwd_hit_2,
    output logic [XLEN-1:0]         fwd_val_2,
    output logic [CW-1:0]           cq_count
);

    cq_state_e state_q;
    cq_state_e state_d;

    logic                             push;
    logic                             pop;
    logic                             store;
    logic                             bypass;
    logic [CW-1:0]                    cnt_nxt;
    logic [REG_ID_WIDTH-1:0]          head_reg_id;
    logic [XLEN-1:0]                  head_val;
    logic [ROB_WIDTH-1:0]             head_rob_id;
    logic [PW-1:0]                    head_ptr;
    logic [CQ_DEPTH-1:0]              ent_vld;
    logic [CQ_DEPTH*REG_ID_WIDTH-1:0] ent_reg_id;
    logic [CQ_DEPTH*XLEN-1:0]         ent_val;

    // A pop never frees a slot for the same cycle's push.
    assign cq_ready = rst_n_in && rdy_in
                   && (cq_count < CW'(CQ_DEPTH));
    assign push     = cq_valid && cq_ready;
    assign pop      = rdy_in && !clear
                   && (state_q == ST_DRAIN)
                   && (cq_count != '0);

`ifdef COMMIT_BYPASS_EN
    assign bypass = push && !clear
                 && (cq_count == '0)
                 && (cq_reg_id != '0);
`else
    assign bypass = 1'b0;
`endif

    // x0 writes are accepted but never stored.
    assign store   = push && (cq_reg_id != '0) && !bypass;
    assign cnt_nxt = cq_count + CW'(store) - CW'(pop);

    commit_fifo #(
        .DEPTH (CQ_DEPTH)
    ) u_fifo (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .push_en     (store),
        .push_reg_id (cq_reg_id),
        .push_val    (cq_val),
        .push_rob_id (cq_rob_id),
        .pop_en      (pop),
        .head_reg_id (head_reg_id),
        .head_val    (head_val),
        .head_rob_id (head_rob_id),
        .count       (cq_count),
        .head_ptr    (head_ptr),
        .ent_vld     (ent_vld),
        .ent_reg_id  (ent_reg_id),
        .ent_val     (ent_val)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rdy_in) begin
            if (clear) begin
                state_d = ST_HOLD;
            end else begin
                unique case (state_q)
                    ST_IDLE:
                        state_d = store ? ST_DRAIN : ST_IDLE;
                    ST_DRAIN, ST_HOLD:
                        state_d = (cnt_nxt == '0) ? ST_IDLE : ST_DRAIN;
                    default:
                        state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        commit_ready  = 1'b0;
        commit_reg_id = '0;
        commit_val    = '0;
        commit_rob_id = '0;
        if (pop) begin
            commit_ready  = 1'b1;
            commit_reg_id = head_reg_id;
            commit_val    = head_val;
            commit_rob_id = head_rob_id;
        end else if (bypass) begin
            commit_ready  = 1'b1;
            commit_reg_id = cq_reg_id;
            commit_val    = cq_val;
            commit_rob_id = cq_rob_id;
        end
    end

    // Walk oldest to youngest so the youngest match wins.
    function automatic logic [XLEN:0] fwd_lookup(
        input logic [REG_ID_WIDTH-1:0]          r,
        input logic [PW-1:0]                    head,
        input logic [CQ_DEPTH-1:0]              vld,
        input logic [CQ_DEPTH*REG_ID_WIDTH-1:0] regs,
        input logic [CQ_DEPTH*XLEN-1:0]         vals
    );
        logic [XLEN:0] res;
        logic [PW-1:0] idx;
        res = '0;
        for (int i = 0; i < CQ_DEPTH; i++) begin
            idx = head + PW'(i);
            if ((r != '0) && vld[idx]
                && (regs[idx*REG_ID_WIDTH +: REG_ID_WIDTH] == r)) begin
                res = {1'b1, vals[idx*XLEN +: XLEN]};
            end
        end
        return res;
    endfunction

    assign {fwd_hit_1, fwd_val_1} =
        fwd_lookup(fwd_reg_1, head_ptr, ent_vld, ent_reg_id, ent_val);
    assign {fwd_hit_2, fwd_val_2} =
        fwd_lookup(fwd_reg_2, head_ptr, ent_vld, ent_reg_id, ent_val);

endmodule

// File: doc/regfile_commit_ctrl.md
REGFILE_COMMIT_CTRL -- requirements
Module: regfile_commit_ctrl

Interface
REQ-001 SHALL have parameter CQ_DEPTH, default 4, commit-queue entries (power of two, 2..16).
REQ-002 SHALL use one clock and an asynchronous, active-low reset: clk_in input 1 system clock; rst_n_in input 1 asynchronous active-low reset.
REQ-003 SHALL have rdy_in input 1: pause when low; clear input 1: pipeline flush.
REQ-004 SHALL have the ROB-side push port:
- cq_valid input 1
- cq_ready output 1
- cq_reg_id input 5
- cq_val input 32
- cq_rob_id input ROB_WIDTH
REQ-005 SHALL have the regfile-side port:
- commit_ready output 1
- commit_reg_id output 5
- commit_val output 32
- commit_rob_id output ROB_WIDTH
REQ-006 SHALL have forward lookup ports n=1,2:
- fwd_reg_n input 5
- fwd_hit_n output 1
- fwd_val_n output 32
REQ-007 SHALL have cq_count output clog2(CQ_DEPTH)+1: occupancy.

Function
REQ-008 SHALL define a push as cq_valid && cq_ready in a cycle with rdy_in high.
REQ-009 SHALL drive cq_ready = rdy_in && (cq_count < CQ_DEPTH); a same-cycle pop SHALL NOT free a slot for a same-cycle push.
REQ-010 SHALL accept a push with cq_reg_id==0 but not store it (x0 drop).
REQ-011 SHALL be an in-order circular queue: head/tail pointers wrap modulo CQ_DEPTH, count tracks occupancy, full is count==CQ_DEPTH, empty is count==0.
REQ-012 SHALL have FSM states IDLE (empty), DRAIN (non-empty, clear low), HOLD (clear high).
REQ-013 SHALL follow these transitions:
- IDLE->DRAIN on push
- DRAIN->IDLE when the last entry pops with no push
- any->HOLD while clear high
- HOLD->DRAIN/IDLE on clear low per count
REQ-014 In DRAIN with rdy_in high, SHALL present the head entry on commit_* with commit_ready=1 and pop it that cycle: one commit per cycle.
REQ-015 In HOLD, IDLE or rdy_in low, SHALL drive commit_ready=0 and commit_reg_id=0, commit_val=0, commit_rob_id=0.
REQ-016 SHALL retain queued entries across clear: committed values are architectural; they drain after clear deasserts.
REQ-017 SHALL have a default latency, push to commit_* presentation, of 1 cycle.
REQ-018 SHALL handle a simultaneous push and pop as follows: count unchanged and order preserved.
REQ-019 SHALL assert fwd_hit_n when any valid entry has reg_id==fwd_reg_n!=0.
REQ-020 SHALL return as fwd_val_n the youngest matching entry's value; the entry being popped this cycle SHALL still count.
REQ-021 fwd_reg_n==0 SHALL give fwd_hit_n=0 and fwd_val_n=0.
REQ-022 While rdy_in is low, all state SHALL hold and no push or pop SHALL occur.

Reset
REQ-023 On rst_n_in low, SHALL clear asynchronously: head=tail=count=0, state IDLE, all entry valid bits 0.
REQ-024 On reset, SHALL drive all outputs 0, including cq_ready and fwd_hit_n, until the first rdy_in-high cycle after release.
REQ-025 Reset mid-drain SHALL discard queued entries without emitting them.

Configuration
REQ-026 SHALL use macro COMMIT_BYPASS_EN to control same-cycle bypass.
REQ-027 When COMMIT_BYPASS_EN is defined and the queue is empty, clear is low and rdy_in is high, a push with reg_id!=0 SHALL appear on commit_* combinationally in the same cycle and not be stored (0-cycle latency).
REQ-028 When COMMIT_BYPASS_EN is undefined, latency SHALL be always 1 cycle via the queue.

Structure
REQ-029 SHALL take ROB_WIDTH, REG_ID_WIDTH=5, XLEN=32 and the FSM state encoding from the shared CPU defines package.
REQ-030 SHALL use one sub-module, commit_fifo: storage, pointers and count; the forward search and FSM SHALL live in the top.

Verification
REQ-031 Push x5=0xDEADBEEF,rob 3 in idle -> commit_ready=1, commit_reg_id=5, commit_val=0xDEADBEEF, commit_rob_id=3 next cycle (same cycle with COMMIT_BYPASS_EN).
REQ-032 Four pushes back-to-back with clear high -> cq_ready=0 after 4th, no commits; clear low -> 4 commits in order on consecutive cycles.
REQ-033 Queue x7=1 then x7=2 held by clear; fwd_reg_1=7 -> fwd_hit_1=1, fwd_val_1=2; fwd_reg_2=0 -> hit 0.
REQ-034 Push x0=0x1234 -> cq_ready=1, count stays 0, no commit emitted.
REQ-035 Drain 2 of 4 entries with pointers wrapped past index 3, then rst_n_in low mid-cycle -> outputs 0 immediately, count=0.
REQ-036 rdy_in low for 3 cycles with 2 queued -> commit_ready=0, count=2 held; rdy_in high -> drain resumes.
